// File: rtl/temp_sensor_scan_ctrl.sv
// Multi-channel ring-oscillator temperature sensor scan controller: settle, count, store per channel.
// Optional threshold alarm is enabled by defining TEMP_SENSOR_ALARM_EN.
module temp_sensor_scan_ctrl #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MIN_LOG2   = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned CH_W       = 2
) (
  input  logic              CLK_REF,
  input  logic              RESET_COUNTERn,
  input  logic              en,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [3:0]        SEL_CONV_TIME,
  input  logic [NUM_CH-1:0] osc_in,
`ifdef TEMP_SENSOR_ALARM_EN
  input  logic [CNT_W-1:0]  thresh_hi,
  input  logic              alarm_clr,
  output logic [NUM_CH-1:0] alarm,
`endif
  output logic [NUM_CH-1:0] osc_en,
  output logic [CNT_W-1:0]  DOUT,
  output logic [CH_W-1:0]   DOUT_CH,
  output logic              ovf,
  output logic              DONE,
  output logic              scan_done,
  output logic              busy
);

  localparam int unsigned WIN_W = MIN_LOG2 + 16;
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StSettle, StCount, StStore} state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0]  scan_mask_q, scan_mask_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [WIN_W-1:0]   win_q, win_d, win_last;
  logic [3:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [CNT_W-1:0]   dout_q, dout_d;
  logic [CH_W-1:0]    dout_ch_q, dout_ch_d;
  logic               ovf_q, ovf_d;
  logic [NUM_CH-1:0]  osc_en_q, osc_en_d;
  logic               done, scan_last;

  logic [NUM_CH-1:0]  sync1_q, sync2_q, prev_q, edges;
  logic [CH_W-1:0]    low_new, low_scan, next_hi;
  logic               has_hi, edge_sel;

  // Two-flop synchroniser plus rising-edge detector per oscillator.
  always_ff @(posedge CLK_REF or negedge RESET_COUNTERn) begin
    if (!RESET_COUNTERn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edges = sync2_q & ~prev_q;

  always_comb begin
    low_new  = '0;
    low_scan = '0;
    next_hi  = '0;
    has_hi   = 1'b0;
    edge_sel = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) low_new = CH_W'(i);
      if (scan_mask_q[i]) low_scan = CH_W'(i);
      if (scan_mask_q[i] && (i > int'(ch_q))) begin
        has_hi  = 1'b1;
        next_hi = CH_W'(i);
      end
      if (ch_q == CH_W'(i)) edge_sel = edges[i];
    end
    win_last = (WIN_W'(1) << (MIN_LOG2 + 32'(sel_q))) - WIN_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    scan_mask_d = scan_mask_q;
    settle_d    = settle_q;
    win_d       = win_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    dout_d      = dout_q;
    dout_ch_d   = dout_ch_q;
    ovf_d       = ovf_q;
    done        = 1'b0;
    scan_last   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d      = '0;
        ovf_pend_d = 1'b0;
        if (start && (|ch_mask)) begin
          scan_mask_d = ch_mask;
          ch_d        = low_new;
          settle_d    = '0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        cnt_d      = '0;
        ovf_pend_d = 1'b0;
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          sel_d   = SEL_CONV_TIME;
          win_d   = '0;
          state_d = StCount;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      StCount: begin
        if (edge_sel) begin
          if (cnt_q == CntMax) ovf_pend_d = 1'b1;
          else                 cnt_d      = cnt_q + CNT_W'(1);
        end
        if (win_q == win_last) state_d = StStore;
        else                   win_d   = win_q + WIN_W'(1);
      end
      StStore: begin
        done       = 1'b1;
        scan_last  = !has_hi;
        dout_d     = cnt_q;
        dout_ch_d  = ch_q;
        ovf_d      = ovf_pend_q;
        cnt_d      = '0;
        ovf_pend_d = 1'b0;
        settle_d   = '0;
        if (has_hi) begin
          ch_d    = next_hi;
          state_d = StSettle;
        end else if (continuous) begin
          ch_d    = low_scan;
          state_d = StSettle;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    // Disable aborts everything but leaves the last published result intact.
    if (!en) begin
      state_d    = StIdle;
      done       = 1'b0;
      scan_last  = 1'b0;
      dout_d     = dout_q;
      dout_ch_d  = dout_ch_q;
      ovf_d      = ovf_q;
      cnt_d      = '0;
      ovf_pend_d = 1'b0;
    end

    osc_en_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      osc_en_d[i] = (ch_d == CH_W'(i)) && ((state_d == StSettle) || (state_d == StCount));
    end
  end

  always_ff @(posedge CLK_REF or negedge RESET_COUNTERn) begin
    if (!RESET_COUNTERn) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      scan_mask_q <= '0;
      settle_q    <= '0;
      win_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      dout_q      <= '0;
      dout_ch_q   <= '0;
      ovf_q       <= 1'b0;
      osc_en_q    <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      scan_mask_q <= scan_mask_d;
      settle_q    <= settle_d;
      win_q       <= win_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      dout_q      <= dout_d;
      dout_ch_q   <= dout_ch_d;
      ovf_q       <= ovf_d;
      osc_en_q    <= osc_en_d;
    end
  end

  assign osc_en    = osc_en_q;
  assign DOUT      = dout_q;
  assign DOUT_CH   = dout_ch_q;
  assign ovf       = ovf_q;
  assign DONE      = done;
  assign scan_done = scan_last;
  assign busy      = (state_q != StIdle);

`ifdef TEMP_SENSOR_ALARM_EN
  logic [NUM_CH-1:0] alarm_q, alarm_d, alarm_set;

  // Set wins over a simultaneous clear.
  always_comb begin
    alarm_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      alarm_set[i] = done && (ch_q == CH_W'(i)) && (cnt_q > thresh_hi);
    end
    alarm_d = (alarm_clr ? '0 : alarm_q) | alarm_set;
  end

  always_ff @(posedge CLK_REF or negedge RESET_COUNTERn) begin
    if (!RESET_COUNTERn) alarm_q <= '0;
    else                 alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: doc/temp_sensor_scan_ctrl.md
Name: temp_sensor_scan_ctrl

Overview:
Parametrised multi-channel digital back-end for ring-oscillator temperature sensors. It scans NUM_CH oscillator channels in sequence and gates each channel's oscillator on. It counts oscillator edges over a programmable window of CLK_REF cycles and presents each result with a channel tag and a DONE strobe. It extends the single-channel counter with these features: channel masking, a settle delay, continuous scan, saturation/overflow flagging and an optional threshold alarm.

Parameters:
NUM_CH, 4, number of oscillator channels (1..16)
CNT_W, 24, edge-counter and DOUT width
MIN_LOG2, 4, window = 2^(SEL_CONV_TIME+MIN_LOG2) CLK_REF cycles
SETTLE_CYC, 8, CLK_REF cycles after osc_en before counting (>=1)
CH_W, 2, channel index width, must be >= ceil(log2(NUM_CH)), min 1

Ports:
CLK_REF  input  1  reference clock, sole clock of the block
RESET_COUNTERn  input  1  asynchronous active-low reset
en  input  1  block enable; low aborts any activity
start  input  1  one-cycle request to begin a scan
continuous  input  1  1 = restart the scan after the last channel
ch_mask  input  NUM_CH  channels included in the scan
SEL_CONV_TIME  input  4  window exponent select
osc_in  input  NUM_CH  raw oscillator outputs, asynchronous to CLK_REF
osc_en  output  NUM_CH  one-hot oscillator enable
DOUT  output  CNT_W  last conversion result
DOUT_CH  output  CH_W  channel index of DOUT
ovf  output  1  DOUT saturated
DONE  output  1  one-cycle strobe: DOUT/DOUT_CH/ovf updated
scan_done  output  1  one-cycle strobe with the last channel's DONE
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: osc_en=0, DOUT=0, DOUT_CH=0, ovf=0, DONE=0, scan_done=0, busy=0, FSM=IDLE, all counters 0.
- Each osc_in bit uses a 2-flop synchroniser followed by a rising-edge detector, giving one count per CLK_REF cycle with a detected edge.
- Valid counting requires f_osc < f_CLK_REF/2. Faster oscillators undercount; the block does not flag this.
- IDLE: on start=1 with en=1 and ch_mask!=0:
  - latch ch_mask into scan_mask;
  - select the lowest set bit;
  - go to SETTLE.
  - start with ch_mask=0 is ignored.
- start while busy is ignored.
- SETTLE:
  - osc_en[ch]=1 and the edge counter is held at 0;
  - hold for SETTLE_CYC cycles;
  - latch SEL_CONV_TIME and go to COUNT.
- COUNT:
  - osc_en[ch] stays 1 and the window counter runs 2^(SEL_CONV_TIME+MIN_LOG2) cycles;
  - the edge counter increments on each detected edge and saturates at 2^CNT_W-1;
  - an edge that arrives while saturated sets the sticky internal ovf_pend.
- STORE (1 cycle):
  - DOUT<=count, DOUT_CH<=ch, ovf<=ovf_pend, DONE=1;
  - osc_en<=0 and ovf_pend is cleared;
  - scan_done=1 if no higher set bit remains in scan_mask.
- After STORE:
  - next higher set channel → SETTLE;
  - else continuous=1 → lowest set channel of scan_mask → SETTLE; scan_mask is not re-latched;
  - else → IDLE, busy=0.
- continuous is sampled in STORE. Deasserting it ends the scan after the current pass.
- en=0 in any state: the next cycle is IDLE and osc_en=0. There is no DONE or scan_done, and DOUT/DOUT_CH/ovf keep their values.
- Asynchronous reset mid-operation returns every signal to its reset value immediately.
- DOUT is stable between DONE strobes. With NUM_CH=1, DOUT_CH is constantly 0.

Optional Feature:
TEMP_SENSOR_ALARM_EN
- Defined: adds these ports:
  - thresh_hi input CNT_W;
  - alarm_clr input 1;
  - alarm output NUM_CH.
- Alarm behaviour:
  - In STORE, if count > thresh_hi, alarm[ch] is set, and it is sticky.
  - alarm_clr=1 clears all bits next cycle.
  - A simultaneous set and clear leaves the bit set.
  - Reset value of alarm is 0.
- Undefined: these ports and the logic are absent, and all other behaviour is identical.

Test Plan:
- Setup for the scenarios below unless stated: NUM_CH=4, MIN_LOG2=4, SETTLE_CYC=8, SEL_CONV_TIME=0 (16-cycle window). The bench drives osc_in synchronous to CLK_REF.
- Single channel: ch_mask=4'b0100, osc period 4 cycles, start → osc_en=4'b0100 for 8+16 cycles. Then DOUT=4, DOUT_CH=2, ovf=0, and DONE and scan_done pulse together. busy drops the next cycle.
- Multi-channel scan: ch_mask=4'b1011, periods 4/8/2 on ch0/ch1/ch3 → three DONEs in order with (DOUT_CH,DOUT) = (0,4), (1,2), (3,8). scan_done only with ch3.
- Saturation: CNT_W=3, SEL_CONV_TIME=1 (32 cycles), period 2 → DOUT=7 and ovf=1. A following conversion at period 8 gives DOUT=4 and ovf=0.
- Abort: en dropped after 10 cycles of COUNT → osc_en=0 and busy=0 next cycle. There is no DONE and DOUT keeps its prior value. A start pulse during busy in a separate run is ignored.
- Continuous: continuous=1, ch_mask=4'b0011 → DONE sequence for ch 0,1,0,1… with scan_done every second DONE. Clearing continuous mid-pass → the scan stops after ch1.
- Alarm (macro defined): thresh_hi=3, ch2 result 4 → alarm=4'b0100. Pulsing alarm_clr → alarm=0 next cycle.
